// File: rtl/ft2232h_tx_arbiter_if.sv
// Bundle of FT2232H write-port and per-source stream signals for the TX arbiter.
// The master side is the arbiter. The slave side is the FT2232H together with the source FIFOs.
interface ft2232h_tx_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic                   en_i;
    logic                   txe_i;
    logic                   wr_o;
    logic                   oe_o;
    logic [7:0]             adbus_o;
    logic [NUM_SRC-1:0]     src_avail_i;
    logic [NUM_SRC-1:0]     src_valid_i;
    logic [8*NUM_SRC-1:0]   src_data_i;
    logic [NUM_SRC-1:0]     src_ready_o;
    logic [NUM_SRC-1:0]     grant_o;
    logic                   busy_o;
    logic [7:0]             seq_o;

    modport master (
        input  en_i, txe_i, src_avail_i, src_valid_i, src_data_i,
        output wr_o, oe_o, adbus_o, src_ready_o, grant_o, busy_o, seq_o
    );

    modport slave (
        output en_i, txe_i, src_avail_i, src_valid_i, src_data_i,
        input  wr_o, oe_o, adbus_o, src_ready_o, grant_o, busy_o, seq_o
    );
endinterface

// File: rtl/ft2232h_tx_arbiter.sv
// Round-robin packet arbiter for the FT2232H synchronous write port. Each burst is
// the header A0|idx, then the sequence byte, then BURST_LEN payload bytes from one source.
module ft2232h_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BURST_LEN = 64
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    ft2232h_tx_arbiter_if.master bus
);
    localparam int         IDX_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

    state_t             state_q, state_d;
    logic               obuf_v;
    logic [7:0]         obuf_d;
    logic [IDX_W-1:0]   idx_q, last_q, pick_idx, hi_idx, lo_idx;
    logic               hi_ok, lo_ok, pick_ok;
    logic [NUM_SRC-1:0] pick_oh, grant_q, ready_d;
    logic               busy_q;
    logic [7:0]         seq_q, cnt_q;
    logic               xfer, load_ok, load, hs, sel_valid;
    logic [7:0]         load_d, sel_data;

    assign xfer    = obuf_v & ~bus.txe_i;
    assign load_ok = ~obuf_v | ~bus.txe_i;

    // Round-robin choice: the lowest requester above last wins, otherwise the lowest overall.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        hi_ok  = 1'b0;
        hi_idx = '0;
        lo_ok  = 1'b0;
        lo_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_avail_i[i]) begin
                lo_ok  = 1'b1;
                lo_idx = IDX_W'(i);
                if (i > int'(last_q)) begin
                    hi_ok  = 1'b1;
                    hi_idx = IDX_W'(i);
                end
            end
        end
        pick_ok  = lo_ok;
        pick_idx = hi_ok ? hi_idx : lo_idx;
        for (int i = 0; i < NUM_SRC; i++) begin
            pick_oh[i] = (pick_idx == IDX_W'(i));
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_valid = bus.src_valid_i[i];
                sel_data  = bus.src_data_i[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: sequential state uses non-blocking assignments only, which keeps evaluation order irrelevant.
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.en_i && pick_ok)      state_d = HDR;
            HDR:     if (load_ok)                  state_d = SEQ;
            SEQ:     if (load_ok)                  state_d = DATA;
            DATA:    if (hs && cnt_q == LAST_CNT)  state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Output-buffer load and source pop strobes
    always_comb begin
        load    = 1'b0;
        load_d  = obuf_d;
        hs      = 1'b0;
        ready_d = '0;
        case (state_q)
            HDR: begin
                load   = load_ok;
                load_d = 8'hA0 | 8'(idx_q);
            end
            SEQ: begin
                load   = load_ok;
                load_d = seq_q;
            end
            DATA: begin
                hs     = load_ok & sel_valid;
                load   = hs;
                load_d = sel_data;
                for (int i = 0; i < NUM_SRC; i++) begin
                    ready_d[i] = (idx_q == IDX_W'(i)) & load_ok;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            obuf_v  <= 1'b0;
            obuf_d  <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            // A load during a transfer replaces the byte without a bubble.
            if (load) begin
                obuf_v <= 1'b1;
                obuf_d <= load_d;
            end else if (xfer) begin
                obuf_v <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (bus.en_i && pick_ok) begin
                        idx_q   <= pick_idx;
                        grant_q <= pick_oh;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SEQ: begin
                    if (load_ok) seq_q <= seq_q + 8'd1;
                end
                DATA: begin
                    if (hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            last_q  <= idx_q;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.wr_o        = ~xfer;
    assign bus.oe_o        = 1'b1;
    assign bus.adbus_o     = obuf_d;
    assign bus.src_ready_o = ready_d;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy_q;
    assign bus.seq_o       = seq_q;
endmodule
